checker_sequencer: RTL
======================

CHECKER_SEQUENCER -- requirements
Module: checker_sequencer

Interface
REQ-001 SHALL have parameter DEPTH_W, default 16, giving the width of the nesting-depth counter.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 bit each: requester n presents a character.
REQ-005 SHALL have ports req0_data/req1_data, input, 8 bits each: ASCII character.
REQ-006 SHALL have ports req0_last/req1_last, input, 1 bit each: the presented character is the final character of the string.
REQ-007 SHALL have ports req0_ready/req1_ready, output, 1 bit each: character accepted when valid and ready are both high at posedge.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done_valid, output, 1 bit: one-cycle verdict pulse.
REQ-010 SHALL have port done_id, output, 1 bit: requester that the verdict belongs to.
REQ-011 SHALL have port done_ok, output, 1 bit: the string's begin/end keywords are balanced.

Function
REQ-012 SHALL arbitrate whole strings between two requesters; characters from different strings are never interleaved.
REQ-013 SHALL implement the FSM states IDLE, STREAM, FLUSH and REPORT.
REQ-014 IDLE: if any reqN_valid is high, SHALL grant and move to STREAM; when both are high, SHALL grant the requester not granted last (round-robin); the first grant after reset goes to req0.
REQ-015 The grant decision in IDLE SHALL take one cycle; reqN_ready SHALL be low in IDLE.
REQ-016 STREAM: SHALL hold ready high for the granted requester only and low for the other; a low valid stalls without state change.
REQ-017 Each accepted character SHALL be fed to the scanner in the same cycle; the scanner state updates at that edge.
REQ-018 An accepted character with last=1 SHALL move the FSM to FLUSH, with ready low from the next cycle.
REQ-019 FLUSH: SHALL feed one implicit space to the scanner so that a final keyword without a trailing space is counted, then move to REPORT.
REQ-020 REPORT: SHALL pulse done_valid for exactly one cycle with done_id equal to the granted requester, clear the scanner to its idle state, and return to IDLE.
REQ-021 done_valid SHALL assert exactly 2 cycles after the last-character handshake edge.
REQ-022 Scanner: words are separated by space (0x20); comparison is case-insensitive for A-Z.
REQ-023 Scanner: a word exactly equal to "begin" SHALL increment depth; a word exactly equal to "end" SHALL decrement depth; any other word SHALL be ignored (e.g. "beginx", "xend").
REQ-024 Scanner: repeated spaces SHALL be empty words with no effect.
REQ-025 An "end" at depth 0 SHALL set a sticky underflow flag; depth SHALL be frozen for the rest of the string.
REQ-026 A "begin" at depth 2^DEPTH_W-1 SHALL set a sticky overflow flag; depth SHALL be frozen for the rest of the string.
REQ-027 done_ok SHALL equal (depth==0 and no underflow and no overflow).
REQ-028 done_id and done_ok SHALL be 0 whenever done_valid is 0.
REQ-029 A requester whose valid is high during another requester's string SHALL wait until the FSM returns to IDLE; no request is dropped.
REQ-030 A single-character string (last on the first character) SHALL be legal and SHALL follow the same latency.

Reset
REQ-031 While reset is high: FSM SHALL be in IDLE; scanner depth and flags SHALL be 0; round-robin pointer SHALL favour req0; all ready outputs, busy, done_valid, done_id and done_ok SHALL be 0.
REQ-032 Reset mid-string SHALL discard the partial string with no verdict; any pending REPORT SHALL be suppressed.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the ASCII constants (space, 'b','e','g','i','n','d'), the upper-to-lower case offset 0x20 and the default DEPTH_W.
REQ-034 The per-character scanner SHALL be a sub-module named block_scanner, with ports clk, reset, clear, char_valid, char (8 bits), depth, underflow and overflow.
REQ-035 The arbiter and FSM SHALL reside in checker_sequencer.

Verification
REQ-036 req0 sends "bEgIn EnD" with last on "D" -> done_valid 2 cycles later, done_id=0, done_ok=1.
REQ-037 req1 sends "end begin " -> done_ok=0 (underflow is sticky despite the later begin).
REQ-038 req0 and req1 both valid in the same IDLE cycle twice in a row -> grant order req0, req1, req0, req1; no interleaved characters; 4 verdicts.
REQ-039 req0 sends "begin  beginx begin" -> done_ok=0 (depth 2); then "begin end" -> done_ok=1 (scanner cleared between strings).
REQ-040 req0 valid toggles low mid-string -> FSM stays in STREAM; the verdict matches the unstalled run.
REQ-041 Reset asserted after "begin " of req1 -> no done_valid; the next string "end" on req0 -> done_ok=0 with done_id=0.

Source files
------------

// File: rtl/checker_sequencer_pkg.sv
// Shared types and constants for the begin/end checker sequencer.
// Holds the FSM encoding, ASCII keyword letters and the default depth width.
package checker_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_REPORT
  } state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6e;
  localparam logic [7:0] CH_D     = 8'h64;
  localparam logic [7:0] CASE_OFS = 8'h20;

  localparam int DEPTH_W_DEF = 16;

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5a) ? c + CASE_OFS : c;
  endfunction

endpackage

// File: rtl/checker_sequencer_scanner.sv
// Per-character word scanner tracking begin/end nesting depth.
// Keyword matches are resolved on the space that terminates a word.
module block_scanner
  import checker_sequencer_pkg::*;
#(
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               char_valid,
  input  logic [7:0]         char,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               overflow
);

  logic [DEPTH_W-1:0] r_depth;
  logic               r_uf;
  logic               r_of;
  logic [2:0]         r_len;
  logic               r_mb;
  logic               r_me;

  logic [7:0] w_lc;
  logic       w_sp;
  logic       w_b_ok;
  logic       w_e_ok;
  logic       w_hit_b;
  logic       w_hit_e;
  logic       w_frozen;

  assign w_lc = to_lower(char);
  assign w_sp = (char == CH_SPACE);

  always_comb begin
    w_b_ok = 1'b0;
    w_e_ok = 1'b0;
    case (r_len)
      3'd0: begin
        w_b_ok = (w_lc == CH_B);
        w_e_ok = (w_lc == CH_E);
      end
      3'd1: begin
        w_b_ok = (w_lc == CH_E);
        w_e_ok = (w_lc == CH_N);
      end
      3'd2: begin
        w_b_ok = (w_lc == CH_G);
        w_e_ok = (w_lc == CH_D);
      end
      3'd3: w_b_ok = (w_lc == CH_I);
      3'd4: w_b_ok = (w_lc == CH_N);
      default: ;
    endcase
  end

  assign w_hit_b  = w_sp && r_mb && (r_len == 3'd5);
  assign w_hit_e  = w_sp && r_me && (r_len == 3'd3);
  assign w_frozen = r_uf | r_of;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_depth <= '0;
      r_uf    <= 1'b0;
      r_of    <= 1'b0;
      r_len   <= 3'd0;
      r_mb    <= 1'b1;
      r_me    <= 1'b1;
    end else if (char_valid) begin
      if (w_sp) begin
        r_len <= 3'd0;
        r_mb  <= 1'b1;
        r_me  <= 1'b1;
        if (!w_frozen && w_hit_b) begin
          if (r_depth == '1) r_of <= 1'b1;
          else r_depth <= r_depth + 1'b1;
        end
        if (!w_frozen && w_hit_e) begin
          if (r_depth == '0) r_uf <= 1'b1;
          else r_depth <= r_depth - 1'b1;
        end
      end else begin
        r_mb <= r_mb & w_b_ok;
        r_me <= r_me & w_e_ok;
        // saturate: any word longer than 5 already fails both matches
        if (r_len != 3'd7) r_len <= r_len + 3'd1;
      end
    end
  end

  assign depth     = r_depth;
  assign underflow = r_uf;
  assign overflow  = r_of;

endmodule

// File: rtl/checker_sequencer.sv
// Two-requester string arbiter feeding a begin/end balance scanner.
// Whole strings are granted round-robin; each yields one verdict pulse.
module checker_sequencer
  import checker_sequencer_pkg::*;
#(
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       busy,
  output logic       done_valid,
  output logic       done_id,
  output logic       done_ok
);

  state_t r_state;
  state_t w_next;
  logic   r_grant;
  logic   r_prio;
  logic   w_pick;
  logic   w_any;

  logic       w_sel_valid;
  logic [7:0] w_sel_data;
  logic       w_sel_last;
  logic       w_stream;
  logic       w_acc;
  logic       w_on;

  logic [DEPTH_W-1:0] w_depth;
  logic               w_uf;
  logic               w_of;
  logic               w_sc_valid;
  logic [7:0]         w_sc_char;

  assign w_any       = req0_valid | req1_valid;
  assign w_sel_valid = r_grant ? req1_valid : req0_valid;
  assign w_sel_data  = r_grant ? req1_data : req0_data;
  assign w_sel_last  = r_grant ? req1_last : req0_last;
  assign w_stream    = (r_state == S_STREAM);
  assign w_acc       = w_stream & w_sel_valid;
  assign w_on        = ~reset;

  always_comb begin
    w_next = r_state;
    w_pick = r_grant;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = S_STREAM;
          w_pick = (req0_valid & req1_valid) ? r_prio : req1_valid;
        end
      end
      S_STREAM: if (w_acc && w_sel_last) w_next = S_FLUSH;
      S_FLUSH:  w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) begin
        r_grant <= w_pick;
        r_prio  <= ~w_pick;
      end
    end
  end

  // the flush space closes a trailing keyword with no separator after it
  assign w_sc_valid = w_on & (w_acc | (r_state == S_FLUSH));
  assign w_sc_char  = (r_state == S_FLUSH) ? CH_SPACE : w_sel_data;

  block_scanner #(
    .DEPTH_W(DEPTH_W)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .clear     (r_state == S_REPORT),
    .char_valid(w_sc_valid),
    .char      (w_sc_char),
    .depth     (w_depth),
    .underflow (w_uf),
    .overflow  (w_of)
  );

  assign req0_ready = w_on & w_stream & ~r_grant;
  assign req1_ready = w_on & w_stream & r_grant;
  assign busy       = w_on & (r_state != S_IDLE);
  assign done_valid = w_on & (r_state == S_REPORT);
  assign done_id    = done_valid & r_grant;
  assign done_ok    = done_valid & (w_depth == '0) & ~w_uf & ~w_of;

endmodule
